dmem_ctrl: RTL and testbench

Two-port arbiter and access sequencer in front of the word-wide data memory (1 read port, 1 write port, 1-cycle read latency). Accepts load/store requests from the core LSU (port 0) and the debug/DMA port (port 1), grants one at a time, performs read-modify-write for byte and halfword stores, and returns sign- or zero-extended load data. All sub-word lane handling lives here; the memory sees only word-aligned word accesses.

---
 rtl/dmem_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Two-port arbiter and access sequencer in front of a word-wide
//            data memory (1 read port, 1 write port, 1-cycle read latency).
//            Handles byte/halfword lanes, load extension and read-modify-write
//            for sub-word stores. The memory only sees word accesses.
// Ports    : clk, rst (async, active-low)
//            reqN_valid/ready/we/addr/wdata/size  request ports (N=0,1)
//            rspN_valid/rdata/err                 completion pulses
//            mem_rd_addr/mem_rd_data              memory read port
//            mem_wr_addr/mem_wr_data/mem_we       memory write port
// Config   : DMEM_RR_EN defined -> round-robin grant, else port 0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [2:0]  req0_size,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [2:0]  req1_size,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_we
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        port_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;

    // Port selected in IDLE (0 or 1).
    logic        gnt;

`ifdef DMEM_RR_EN
    // Port that wins the next tie; flips to the other port on each accept.
    logic        prio_q;

    always_comb begin
        if (req0_valid && req1_valid) gnt = prio_q;
        else                          gnt = ~req0_valid & req1_valid;
    end
`else
    always_comb begin
        gnt = ~req0_valid & req1_valid;
    end
`endif

    logic        sel_valid;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;
    logic        idle;
    logic        accept;
    logic        sel_err;
    logic        size_ok;
    logic        align_ok;
    logic        range_ok;

    assign idle       = (state_q == S_IDLE);
    assign sel_valid  = gnt ? req1_valid : req0_valid;
    assign sel_we     = gnt ? req1_we    : req0_we;
    assign sel_addr   = gnt ? req1_addr  : req0_addr;
    assign sel_wdata  = gnt ? req1_wdata : req0_wdata;
    assign sel_size   = gnt ? req1_size  : req0_size;
    assign accept     = idle & sel_valid;
    assign req0_ready = idle & ~gnt;
    assign req1_ready = idle &  gnt;

    always_comb begin
        size_ok = 1'b0;
        case (sel_size)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = ~sel_we; // unsigned stores do not exist
            default:                size_ok = 1'b0;
        endcase
        align_ok = 1'b1;
        case (sel_size[1:0])
            2'b01:   align_ok = ~sel_addr[0];
            2'b10:   align_ok = (sel_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        range_ok = (sel_addr[31:2] < 30'(DEPTH));
        sel_err  = ~(size_ok & align_ok & range_ok);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sel_err)                             state_d = S_ERR;
                    else if (sel_we && sel_size == 3'b010)   state_d = S_WRITE;
                    else                                     state_d = S_RD;
                end
            end
            S_RD:    state_d = we_q ? S_WRITE : S_LOAD;
            S_LOAD:  state_d = S_IDLE;
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 3'd0;
`ifdef DMEM_RR_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                port_q  <= gnt;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                size_q  <= sel_size;
`ifdef DMEM_RR_EN
                prio_q  <= ~gnt;
`endif
            end
        end
    end

    // Lane selection from the word returned by memory.
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem_rd_data[7:0];
            2'd1:    lane_b = mem_rd_data[15:8];
            2'd2:    lane_b = mem_rd_data[23:16];
            default: lane_b = mem_rd_data[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

        case (size_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'd0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'd0, lane_h};
            3'b010:  load_data = mem_rd_data;
            default: load_data = 32'd0;
        endcase

        // Read-modify-write: keep the fetched word, replace the addressed lane.
        merge_data = mem_rd_data;
        if (size_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q[1:0] == 2'b01) begin
            if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
            else           merge_data[15:0]  = wdata_q[15:0];
        end else begin
            merge_data = wdata_q;
        end
    end

    logic        done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always_comb begin
        mem_rd_addr = 32'd0;
        mem_wr_addr = 32'd0;
        mem_wr_data = 32'd0;
        mem_we      = 1'b0;
        done        = 1'b0;
        rsp_rdata   = 32'd0;
        rsp_err     = 1'b0;
        case (state_q)
            S_RD: mem_rd_addr = {addr_q[31:2], 2'b00};
            S_LOAD: begin
                done      = 1'b1;
                rsp_rdata = load_data;
            end
            S_WRITE: begin
                done        = 1'b1;
                mem_we      = 1'b1;
                mem_wr_addr = {addr_q[31:2], 2'b00};
                mem_wr_data = merge_data;
            end
            S_ERR: begin
                done    = 1'b1;
                rsp_err = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp0_valid = done & ~port_q;
    assign rsp1_valid = done &  port_q;
    assign rsp0_rdata = port_q ? 32'd0 : rsp_rdata;
    assign rsp1_rdata = port_q ? rsp_rdata : 32'd0;
    assign rsp0_err   = rsp_err & ~port_q;
    assign rsp1_err   = rsp_err &  port_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Scoreboard bench for dmem_ctrl with a word-array reference model
//            and a behavioural 1-cycle-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        rv[2];
    logic        rwe[2];
    logic [31:0] ra[2];
    logic [31:0] rwd[2];
    logic [2:0]  rsz[2];

    logic        rdy0, rdy1, rspv0, rspv1, rerr0, rerr1, mem_we;
    logic [31:0] rd0, rd1, mem_rd_addr, mem_wr_addr, mem_wr_data;
    logic [31:0] mem_rd_data;

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(rdy0), .req0_we(rwe[0]), .req0_addr(ra[0]),
        .req0_wdata(rwd[0]), .req0_size(rsz[0]),
        .rsp0_valid(rspv0), .rsp0_rdata(rd0), .rsp0_err(rerr0),
        .req1_valid(rv[1]), .req1_ready(rdy1), .req1_we(rwe[1]), .req1_addr(ra[1]),
        .req1_wdata(rwd[1]), .req1_size(rsz[1]),
        .rsp1_valid(rspv1), .rsp1_rdata(rd1), .rsp1_err(rerr1),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we)
    );

    // Behavioural memory seen by the DUT.
    logic [31:0] phys[DEPTH];
    always @(posedge clk) begin
        if (mem_we) phys[mem_wr_addr[3:2]] <= mem_wr_data;
        mem_rd_data <= phys[mem_rd_addr[3:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
    rsp_t rq0[$];
    rsp_t rq1[$];
    wr_t  wq[$];
    int   gl[$];
    logic [31:0] ref_mem[DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: architectural view of a load/store on a word array.
    function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] sz, output logic err, output logic [31:0] rdata,
                                  output int lat, output bit wr, output logic [31:0] nw);
        int unsigned nb;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] word;
        bit legal;
        err = 1'b0; rdata = 32'd0; wr = 1'b0; nw = 32'd0;
        legal = (sz == 3'd0 || sz == 3'd1 || sz == 3'd2 || (!we && (sz == 3'd4 || sz == 3'd5)));
        nb = 1 << sz[1:0];
        if (!legal || (a % nb) != 0 || (a / 4) >= DEPTH) err = 1'b1;
        if (err || (we && sz == 3'd2)) lat = 1;
        else                           lat = 2;
        if (!err) begin
            word = ref_mem[a / 4];
            sh   = (a % 4) * 8;
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nb * 8)) - 32'd1);
            if (!we) begin
                rdata = (word >> sh) & mask;
                if (sz < 3'd4 && nb < 4 && rdata[nb * 8 - 1]) rdata = rdata | ~mask;
            end else begin
                nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
                ref_mem[a / 4] = nw;
                wr = 1'b1;
            end
        end
    endfunction

    task automatic drive(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] sz);
        bit ok;
        int k, lat;
        logic e;
        logic [31:0] rdv, nw;
        bit wr;
        rsp_t r;
        wr_t w;
        @(posedge clk); #1;
        rv[p] = 1'b1; rwe[p] = we; ra[p] = a; rwd[p] = wd; rsz[p] = sz;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((p == 0) ? rdy0 : rdy1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: port %0d got no ready, required ready within 2000 cycles", p);
            rv[p] = 1'b0;
            return;
        end
        k = cyc;
        model(we, a, wd, sz, e, rdv, lat, wr, nw);
        r.rdata = rdv; r.err = e; r.cyc = k + lat;
        if (p == 0) rq0.push_back(r); else rq1.push_back(r);
        if (wr) begin
            w.addr = {a[31:2], 2'b00}; w.data = nw; w.cyc = k + lat;
            wq.push_back(w);
        end
        gl.push_back(p);
        @(posedge clk); #1;
        rv[p] = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or write.
    rsp_t m0, m1;
    wr_t  mw;
    always @(negedge clk) begin
        if (rst) begin
            if (rspv0) begin
                if (rq0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp0_unexpected: got rsp0_valid=1 required 0");
                end else begin
                    m0 = rq0.pop_front();
                    chk("rsp0_rdata", rd0, m0.rdata);
                    chk("rsp0_err", {31'd0, rerr0}, {31'd0, m0.err});
                    chk("rsp0_cycle", cyc, m0.cyc);
                end
            end
            if (rspv1) begin
                if (rq1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp1_unexpected: got rsp1_valid=1 required 0");
                end else begin
                    m1 = rq1.pop_front();
                    chk("rsp1_rdata", rd1, m1.rdata);
                    chk("rsp1_err", {31'd0, rerr1}, {31'd0, m1.err});
                    chk("rsp1_cycle", cyc, m1.cyc);
                end
            end
            if (mem_we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_we_unexpected: got write of %h to %h, required none", mem_wr_data, mem_wr_addr);
                end else begin
                    mw = wq.pop_front();
                    chk("mem_wr_addr", mem_wr_addr, mw.addr);
                    chk("mem_wr_data", mem_wr_data, mw.data);
                    chk("mem_wr_cycle", cyc, mw.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    bit done_flag;
    bit ok;

    initial begin
        for (int p = 0; p < 2; p++) begin
            rv[p] = 0; rwe[p] = 0; ra[p] = 0; rwd[p] = 0; rsz[p] = 0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        rst = 1'b0;
        #2;
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_rsp0", {31'd0, rspv0}, 32'd0);
        chk("reset_rsp1", {31'd0, rspv1}, 32'd0);
        chk("reset_rd_addr", mem_rd_addr, 32'd0);
        chk("reset_wr_addr", mem_wr_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Initialise the whole memory with known words.
        drive(0, 1, 32'h0, 32'h0102_0304, 3'd2);
        drive(0, 1, 32'h8, 32'hCAFE_F00D, 3'd2);
        drive(0, 1, 32'hC, 32'h8000_7F80, 3'd2);
        drive(0, 1, 32'h4, 32'hDEAD_BEEF, 3'd2);
        drive(0, 0, 32'h4, 0, 3'd2);
        drive(0, 1, 32'h6, 32'h0000_0055, 3'd0);
        repeat (2) @(posedge clk); #1;
        chk("sb_merged_word", phys[1], 32'hDE55_BEEF);
        drive(0, 0, 32'h7, 0, 3'd0);
        drive(0, 0, 32'h7, 0, 3'd4);
        drive(0, 0, 32'h4, 0, 3'd1);
        drive(0, 0, 32'h6, 0, 3'd5);
        drive(1, 0, 32'h5, 0, 3'd1);
        drive(1, 0, 32'h6, 0, 3'd2);
        drive(1, 0, 32'h10, 0, 3'd2);
        drive(1, 1, 32'h8, 32'h12, 3'd4);
        drive(1, 0, 32'h0, 0, 3'd3);
        drive(1, 1, 32'hE, 32'h0000_ABCD, 3'd1);
        drive(1, 0, 32'hC, 0, 3'd2);

        // Arbitration with both ports continuously requesting loads.
        repeat (4) @(posedge clk);
        gl.delete();
`ifdef DMEM_RR_EN
        fork
            begin repeat (4) drive(0, 0, 32'h0, 0, 3'd2); end
            begin repeat (4) drive(1, 0, 32'h4, 0, 3'd2); end
        join
        chk("grant_count", gl.size(), 8);
        for (int i = 1; i < gl.size(); i++) chk("grant_alternate", gl[i], 1 - gl[i-1]);
`else
        done_flag = 1'b0;
        fork
            begin
                repeat (4) drive(0, 0, 32'h0, 0, 3'd2);
                done_flag = 1'b1;
            end
            begin
                @(posedge clk); #1;
                rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 32'h4; rsz[1] = 3'd2;
                while (!done_flag) begin
                    @(negedge clk);
                    if (!done_flag) chk("p1_ready_fixed", {31'd0, rdy1}, 32'd0);
                end
                rv[1] = 1'b0;
            end
        join
        chk("grant_count", gl.size(), 4);
        for (int i = 0; i < gl.size(); i++) chk("grant_port0", gl[i], 0);
`endif
        repeat (4) @(posedge clk);

        // Reset during the write phase of a halfword store to 0x8.
        @(posedge clk); #1;
        rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 32'h8; rwd[1] = 32'h1234; rsz[1] = 3'd1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy1) begin ok = 1'b1; break; end
        end
        chk("rst_test_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        rv[1] = 1'b0;
        @(posedge clk); #1;
        chk("rst_test_we_before", {31'd0, mem_we}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_test_we_dropped", {31'd0, mem_we}, 32'd0);
        chk("rst_test_no_rsp", {30'd0, rspv1, rspv0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_test_word_kept", phys[2], ref_mem[2]);
        drive(0, 0, 32'h8, 0, 3'd2);

        // Randomized traffic on both ports.
        fork
            begin
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    drive(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)),
                          $urandom, 3'($urandom_range(0, 7)));
                end
            end
            begin
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    drive(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)),
                          $urandom, 3'($urandom_range(0, 7)));
                end
            end
        join

        repeat (10) @(posedge clk);
        #1;
        chk("rsp0_pending", rq0.size(), 0);
        chk("rsp1_pending", rq1.size(), 0);
        chk("wr_pending", wq.size(), 0);
        for (int i = 0; i < DEPTH; i++) chk("final_mem", phys[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
